// File: rtl/finish_ctrl.sv
// rtl/finish_ctrl.sv - multi-channel end-of-test controller with drain and watchdog
//
// Counts per-channel event pulses up to a latched limit, combines channel
// completion in ANY or ALL mode, drains DRAIN_CYCLES cycles, then raises a
// sticky done and a one-cycle finish_req. A RUN-cycle watchdog (TIMEOUT != 0)
// ends the run early with a sticky timeout flag.
//
// Optional feature macro: FINISH_TASK_EN (simulation only; calls $finish on
// the finish_req cycle). Synthesised logic is the same either way.
//
// Ports:
//   clk        in   clock, posedge
//   rst        in   asynchronous active-high reset
//   start      in   arm/restart; latches limit and mode_all, clears counters
//   limit      in   terminal count per channel
//   mode_all   in   0 = any channel completes the run, 1 = all channels
//   ch_inc     in   per-channel increment pulses (honoured in RUN only)
//   count      out  channel counters, channel i at [i*WIDTH +: WIDTH]
//   ch_done    out  channel counter equals latched limit (not in IDLE)
//   busy       out  state is RUN or DRAIN
//   done       out  sticky, state is DONE
//   timeout    out  sticky, run ended by watchdog
//   finish_req out  one-cycle pulse on the first DONE cycle

module finish_ctrl #(
    parameter int WIDTH        = 8,
    parameter int N_CH         = 4,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        limit,
    input  logic                    mode_all,
    input  logic [N_CH-1:0]         ch_inc,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         ch_done,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic                    finish_req
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_q [N_CH];
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic [31:0]      tcnt;
    logic [31:0]      dcnt;
    logic             timeout_q;
    logic             finish_q;
    logic             cond;
    logic             wd_hit;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign count[i*WIDTH +: WIDTH] = cnt_q[i];
        assign ch_done[i] = (state != S_IDLE) && (cnt_q[i] == limit_q);
    end

    // Completion is judged on registered counts, so leaving RUN lags the
    // final increment by one cycle.
    assign cond = mode_q ? (&ch_done) : (|ch_done);

    always_comb begin
        state_nxt = state;
        wd_hit    = 1'b0;
        case (state)
            S_IDLE: begin
            end
            S_RUN: begin
                // Completion beats the watchdog when both land in one cycle.
                if (cond) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if ((TIMEOUT != 0) && (tcnt == 32'(TIMEOUT - 1))) begin
                    state_nxt = S_DONE;
                    wd_hit    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt == 32'(DRAIN_CYCLES - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: state_nxt = S_IDLE;
        endcase
        // start overrides everything, including a run already in progress.
        if (start) begin
            state_nxt = S_RUN;
            wd_hit    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            tcnt      <= '0;
            dcnt      <= '0;
            timeout_q <= 1'b0;
            finish_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (start) begin
                limit_q   <= limit;
                mode_q    <= mode_all;
                tcnt      <= '0;
                dcnt      <= '0;
                timeout_q <= 1'b0;
                finish_q  <= 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                if (state == S_RUN) begin
                    tcnt <= tcnt + 32'd1;
                    for (int i = 0; i < N_CH; i++) begin
                        // Saturate at the limit; never wrap.
                        if (ch_inc[i] && (cnt_q[i] < limit_q)) begin
                            cnt_q[i] <= cnt_q[i] + WIDTH'(1);
                        end
                    end
                end
                dcnt      <= (state == S_DRAIN) ? dcnt + 32'd1 : 32'd0;
                timeout_q <= timeout_q | wd_hit;
                finish_q  <= (state_nxt == S_DONE) && (state != S_DONE);
            end
        end
    end

    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign timeout    = timeout_q;
    assign finish_req = finish_q;

`ifdef FINISH_TASK_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (finish_req) begin
            $display("finish_ctrl: done timeout=%0d", timeout);
            $finish;
        end
    end
`endif
`else
    // Completion is signalled through finish_req/done only.
`endif

endmodule

// File: tb/tb_finish_ctrl.sv
// tb/tb_finish_ctrl.sv - directed self-checking bench for finish_ctrl

module tb_finish_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  limit;
    logic        mode_all;
    logic [3:0]  ch_inc;

    logic [31:0] count,      w_count;
    logic [3:0]  ch_done,    w_ch_done;
    logic        busy,       w_busy;
    logic        done,       w_done;
    logic        timeout,    w_timeout;
    logic        finish_req, w_finish_req;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    finish_ctrl #(.WIDTH(8), .N_CH(4), .DRAIN_CYCLES(2), .TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit), .mode_all(mode_all),
        .ch_inc(ch_inc), .count(count), .ch_done(ch_done), .busy(busy),
        .done(done), .timeout(timeout), .finish_req(finish_req)
    );

    finish_ctrl #(.WIDTH(8), .N_CH(4), .DRAIN_CYCLES(2), .TIMEOUT(10)) dut_wd (
        .clk(clk), .rst(rst), .start(start), .limit(limit), .mode_all(mode_all),
        .ch_inc(ch_inc), .count(w_count), .ch_done(w_ch_done), .busy(w_busy),
        .done(w_done), .timeout(w_timeout), .finish_req(w_finish_req)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; limit = 8'd0; mode_all = 1'b0; ch_inc = 4'h0;
        tick(); tick();
        chk("rst_count", count, 32'h0);
        chk("rst_ch_done", {28'h0, ch_done}, 32'h0);
        chk("rst_flags", {28'h0, busy, done, timeout, finish_req}, 32'h0);

        // IDLE ignores ch_inc
        rst = 1'b0; ch_inc = 4'hF;
        tick();
        chk("idle_ignore_count", count, 32'h0);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // async reset mid-count
        ch_inc = 4'h0; limit = 8'd9; start = 1'b1;
        tick();
        start = 1'b0; ch_inc = 4'hF;
        tick(); tick();
        chk("midcount", count, 32'h02020202);
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", count, 32'h0);
        chk("post_rst_flags", {28'h0, busy, done, timeout, finish_req}, 32'h0);

        // limit=5, ANY, ch0 pulsed 5x
        ch_inc = 4'h0; limit = 8'd5; mode_all = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_run_busy", {31'h0, busy}, 32'h1);
        chk("t2_run_count", count, 32'h0);
        ch_inc = 4'h1;
        repeat (4) tick();
        chk("t2_count4", count, 32'h4);
        chk("t2_chdone4", {28'h0, ch_done}, 32'h0);
        tick();
        ch_inc = 4'h0;
        chk("t2_count5", count, 32'h5);
        chk("t2_chdone5", {28'h0, ch_done}, 32'h1);
        chk("t2_run_cycle", {30'h0, busy, done}, 32'h2);
        tick();
        chk("t2_drain1", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        tick();
        chk("t2_drain2", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        tick();
        chk("t2_done", {28'h0, busy, done, timeout, finish_req}, 32'h5);
        tick();
        chk("t2_done_hold", {28'h0, busy, done, timeout, finish_req}, 32'h4);
        tick();
        chk("t2_done_hold2", {28'h0, busy, done, timeout, finish_req}, 32'h4);

        // limit=3, ALL, ch3 lags
        limit = 8'd3; mode_all = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_restart_done", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        ch_inc = 4'hF;
        tick(); tick();
        ch_inc = 4'h7;
        tick();
        chk("t3_count", count, 32'h02030303);
        chk("t3_chdone", {28'h0, ch_done}, 32'h7);
        tick();
        chk("t3_saturate", count, 32'h02030303);
        chk("t3_still_busy", {30'h0, busy, done}, 32'h2);
        ch_inc = 4'h8;
        tick();
        ch_inc = 4'hF;
        chk("t3_all_count", count, 32'h03030303);
        chk("t3_all_chdone", {28'h0, ch_done}, 32'hF);
        tick();
        chk("t3_drain1", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        chk("t3_drain_count", count, 32'h03030303);
        tick();
        chk("t3_drain2", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        tick();
        ch_inc = 4'h0;
        chk("t3_done", {28'h0, busy, done, timeout, finish_req}, 32'h5);

        // limit=0: all channels complete in the first RUN cycle
        limit = 8'd0; mode_all = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_chdone", {28'h0, ch_done}, 32'hF);
        chk("t5_run", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        tick();
        chk("t5_drain1_freq", {31'h0, finish_req}, 32'h0);
        tick();
        chk("t5_drain2_freq", {31'h0, finish_req}, 32'h0);
        tick();
        chk("t5_done", {28'h0, busy, done, timeout, finish_req}, 32'h5);

        // start during DRAIN aborts the run
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_in_drain", {30'h0, busy, done}, 32'h2);
        limit = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_count", count, 32'h0);
        chk("t6_restart_chdone", {28'h0, ch_done}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_no_finish_%0d", i),
                {28'h0, busy, done, timeout, finish_req}, 32'h8);
            tick();
        end

        // watchdog: TIMEOUT=10, no events
        limit = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("t4_cycle9", {28'h0, w_busy, w_done, w_timeout, w_finish_req}, 32'h8);
        tick();
        chk("t4_timeout", {28'h0, w_busy, w_done, w_timeout, w_finish_req}, 32'h7);
        chk("t4_no_wd_dut", {28'h0, busy, done, timeout, finish_req}, 32'h8);
        tick();
        chk("t4_timeout_hold", {28'h0, w_busy, w_done, w_timeout, w_finish_req}, 32'h6);

        // completion and watchdog land in the same cycle: completion wins
        limit = 8'd1; mode_all = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        ch_inc = 4'h1;
        tick();
        ch_inc = 4'h0;
        chk("wd_tie_chdone", {28'h0, w_ch_done}, 32'h1);
        tick();
        chk("wd_tie_drain", {28'h0, w_busy, w_done, w_timeout, w_finish_req}, 32'h8);
        tick(); tick();
        chk("wd_tie_done", {28'h0, w_busy, w_done, w_timeout, w_finish_req}, 32'h5);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
